// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_AUX = 1'b1;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } mem_arb_req_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request slot: captures a single command pulse and holds it
// until the arbiter clears it on completion. Flags protocol errors
// (double pulse, or a new pulse while already pending); such pulses are dropped.
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_read,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              clr,
  output logic              pending,
  output mem_arb_req_t      req_type,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              err_det
);

  logic cmd_any;
  logic load;

  // Classify the incoming pulse as a legal capture or a protocol error
  always_comb begin
    cmd_any = cmd_read | cmd_write;
    err_det = (cmd_read & cmd_write) | (cmd_any & pending);
    load    = cmd_any & ~err_det;
  end

  // Pending register; a load can only happen when empty, so it never races clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      req_type <= REQ_READ;
      addr     <= '0;
      wdata    <= '0;
    end else if (load) begin
      pending  <= 1'b1;
      req_type <= cmd_write ? REQ_WRITE : REQ_READ;
      addr     <= cmd_addr;
      if (cmd_write) wdata <= cmd_wdata;
    end else if (clr) begin
      pending  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU sequencer (port 0) and debug/DMA loader
// (port 1) share one memory bus, one outstanding transaction at a time.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise port 0 wins every tie (fixed priority).
//
// state | meaning
// IDLE  | no transaction; pick a winner when any slot is pending
// ISSUE | one-cycle mem_read/mem_write pulse
// WAIT  | waiting for mem_resp, then complete to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_resp,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_resp,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy,
  output logic              err
);

  mem_arb_state_t    state, next_state;
  logic [1:0]        pend;
  logic [1:0]        slot_err;
  logic [1:0]        clr;
  mem_arb_req_t      slot_type  [2];
  logic [ADDR_W-1:0] slot_addr  [2];
  logic [DATA_W-1:0] slot_wdata [2];
  logic              owner;
  logic              winner;
  logic              load_en;
  logic              complete;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_read  (p0_read),
    .cmd_write (p0_write),
    .cmd_addr  (p0_addr),
    .cmd_wdata (p0_wdata),
    .clr       (clr[0]),
    .pending   (pend[0]),
    .req_type  (slot_type[0]),
    .addr      (slot_addr[0]),
    .wdata     (slot_wdata[0]),
    .err_det   (slot_err[0])
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_read  (p1_read),
    .cmd_write (p1_write),
    .cmd_addr  (p1_addr),
    .cmd_wdata (p1_wdata),
    .clr       (clr[1]),
    .pending   (pend[1]),
    .req_type  (slot_type[1]),
    .addr      (slot_addr[1]),
    .wdata     (slot_wdata[1]),
    .err_det   (slot_err[1])
  );

  // Winner selection: port 0 by default, round-robin overrides ties
  always_comb begin
    winner = pend[ARB_PORT_CPU] ? ARB_PORT_CPU : ARB_PORT_AUX;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (&pend) winner = ~last_grant;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (|pend) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (mem_resp) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state strobes: grant load in IDLE, completion in WAIT (mem_resp elsewhere ignored)
  always_comb begin
    load_en  = 1'b0;
    complete = 1'b0;
    unique case (state)
      IDLE:    load_en  = |pend;
      WAIT:    complete = mem_resp;
      default: ;
    endcase
    clr[0] = complete && (owner == ARB_PORT_CPU);
    clr[1] = complete && (owner == ARB_PORT_AUX);
  end

  // Registered outputs: command pulse lands in ISSUE, response pulse the cycle after mem_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= ARB_PORT_CPU;
      busy      <= 1'b0;
      p0_resp   <= 1'b0;
      p1_resp   <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      mem_read  <= load_en && (slot_type[winner] == REQ_READ);
      mem_write <= load_en && (slot_type[winner] == REQ_WRITE);
      busy      <= (next_state != IDLE);
      p0_resp   <= clr[0];
      p1_resp   <= clr[1];
      err       <= err | (|slot_err);
      if (load_en) begin
        mem_addr  <= slot_addr[winner];
        mem_wdata <= slot_wdata[winner];
        owner     <= winner;
      end
      if (complete && (slot_type[owner] == REQ_READ)) begin
        if (owner == ARB_PORT_CPU) p0_rdata <= mem_rdata;
        else                       p1_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who was served last; reset value makes the first tie go to port 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= ARB_PORT_AUX;
    else if (complete) last_grant <= owner;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_resp, p1_resp;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err;

  int total = 0;
  int bad   = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  int n_r0  = 0;
  int n_r1  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_read   (p0_read),
    .p0_write  (p0_write),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_resp   (p0_resp),
    .p0_rdata  (p0_rdata),
    .p1_read   (p1_read),
    .p1_write  (p1_write),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_resp   (p1_resp),
    .p1_rdata  (p1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (mem_read)  n_rd++;
    if (mem_write) n_wr++;
    if (p0_resp)   n_r0++;
    if (p1_resp)   n_r1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait for the next issue, check it, answer one cycle later, check the completion
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_wr,
                       input logic [31:0] rd, input logic exp_port);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_issue"}, (n < 20), 1'b1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_type"}, mem_write, exp_wr);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = rd;
    tick();
    mem_resp  = 1'b0;
    chk({tag, "_resp"}, exp_port ? p1_resp : p0_resp, 1'b1);
    chk({tag, "_other"}, exp_port ? p0_resp : p1_resp, 1'b0);
    if (!exp_wr) chk({tag, "_rdata"}, exp_port ? p1_rdata : p0_rdata, rd);
  endtask

  int s_rd, s_wr, s_r0, s_r1;

  initial begin
    rst_n = 1'b0;
    p0_read = 0; p0_write = 0; p0_addr = 0; p0_wdata = 0;
    p1_read = 0; p1_write = 0; p1_addr = 0; p1_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_p0_resp", p0_resp, 0);
    chk("rst_p1_resp", p1_resp, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    rst_n = 1'b1;
    tick();

    // simultaneous: port 0 write first in both policies (first tie after reset)
    p0_write = 1; p0_addr = 32'h10; p0_wdata = 32'h1111_1111;
    p1_read = 1; p1_addr = 32'h20;
    tick();
    p0_write = 0; p1_read = 0;
    serve("sim_p0", 32'h10, 1'b1, 32'h0, 1'b0);
    chk("sim_wdata", mem_wdata, 32'h1111_1111);
    serve("sim_p1", 32'h20, 1'b0, 32'hCAFE_0001, 1'b1);

    // continuous requests, re-posting in the response cycle: grants 0,1,0,1
    tick();
    p0_read = 1; p0_addr = 32'h30; p1_read = 1; p1_addr = 32'h40;
    tick();
    p0_read = 0; p1_read = 0;
    serve("cont0", 32'h30, 1'b0, 32'hC000_0000, 1'b0);
    p0_read = 1; p0_addr = 32'h31;
    tick();
    p0_read = 0;
    serve("cont1", 32'h40, 1'b0, 32'hC000_0001, 1'b1);
    p1_read = 1; p1_addr = 32'h41;
    tick();
    p1_read = 0;
    serve("cont2", 32'h31, 1'b0, 32'hC000_0002, 1'b0);
    serve("cont3", 32'h41, 1'b0, 32'hC000_0003, 1'b1);
    tick(); tick();

    // single read with exact timing: memory answers 2 cycles after issue
    s_rd = n_rd; s_r1 = n_r1; s_r0 = n_r0;
    p0_read = 1; p0_addr = 32'h100;
    tick();
    p0_read = 0;
    chk("single_t1_mem_read", mem_read, 0);
    tick();
    chk("single_t2_mem_read", mem_read, 1);
    chk("single_t2_addr", mem_addr, 32'h100);
    chk("single_t2_busy", busy, 1);
    tick();
    chk("single_t3_mem_read", mem_read, 0);
    tick();
    mem_resp = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp = 0;
    chk("single_p0_resp", p0_resp, 1);
    chk("single_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("single_busy_done", busy, 0);
    tick();
    chk("single_p0_resp_once", p0_resp, 0);
    tick();
    chk("single_rd_count", n_rd - s_rd, 1);
    chk("single_r0_count", n_r0 - s_r0, 1);
    chk("single_no_p1_resp", n_r1 - s_r1, 0);

    // tie after a port-0 grant: round-robin favours port 1, fixed favours port 0
    p0_write = 1; p0_addr = 32'hA0; p0_wdata = 32'h5555_AAAA;
    p1_read = 1; p1_addr = 32'hB0;
    tick();
    p0_write = 0; p1_read = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    serve("tie_first", 32'hB0, 1'b0, 32'hB0B0_B0B0, 1'b1);
    serve("tie_second", 32'hA0, 1'b1, 32'h0, 1'b0);
`else
    serve("tie_first", 32'hA0, 1'b1, 32'h0, 1'b0);
    serve("tie_second", 32'hB0, 1'b0, 32'hB0B0_B0B0, 1'b1);
`endif
    chk("tie_write_keeps_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick(); tick();

    // back-to-back: new command in the p0_resp cycle issues 2 cycles later
    p0_read = 1; p0_addr = 32'h50;
    tick();
    p0_read = 0;
    serve("b2b_a", 32'h50, 1'b0, 32'h0BAD_F00D, 1'b0);
    p0_read = 1; p0_addr = 32'h60;
    tick();
    p0_read = 0;
    chk("b2b_gap", mem_read, 0);
    tick();
    chk("b2b_issue", mem_read, 1);
    chk("b2b_addr", mem_addr, 32'h60);
    serve("b2b_b", 32'h60, 1'b0, 32'h600D_600D, 1'b0);
    tick(); tick();

    // protocol errors: repeated p1 pulse, then p0 read+write together
    chk("err_clear_before", err, 0);
    s_rd = n_rd; s_wr = n_wr;
    p1_read = 1; p1_addr = 32'h70;
    tick();
    p1_addr = 32'h77;
    tick();
    p1_read = 0;
    chk("err_set", err, 1);
    chk("err_issue", mem_read, 1);
    chk("err_addr_orig", mem_addr, 32'h70);
    p0_read = 1; p0_write = 1; p0_addr = 32'h88;
    tick();
    p0_read = 0; p0_write = 0;
    tick();
    mem_resp = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp = 0;
    chk("err_p1_resp", p1_resp, 1);
    chk("err_p1_rdata", p1_rdata, 32'h1234_5678);
    tick(); tick(); tick();
    chk("err_busy_idle", busy, 0);
    chk("err_rd_dropped", n_rd - s_rd, 1);
    chk("err_wr_dropped", n_wr - s_wr, 0);
    chk("err_sticky", err, 1);

    // reset in WAIT, then a late mem_resp
    p0_read = 1; p0_addr = 32'h90;
    tick();
    p0_read = 0;
    tick();
    tick();
    chk("rstw_busy_wait", busy, 1);
    rst_n = 0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_err", err, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_p0_rdata", p0_rdata, 0);
    chk("rstw_p1_rdata", p1_rdata, 0);
    tick();
    rst_n = 1;
    s_r0 = n_r0; s_r1 = n_r1; s_rd = n_rd;
    tick();
    mem_resp = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp = 0;
    chk("rstw_no_p0_resp", p0_resp, 0);
    chk("rstw_idle", busy, 0);
    tick(); tick(); tick();
    chk("rstw_resp_count", (n_r0 - s_r0) + (n_r1 - s_r1), 0);
    chk("rstw_no_reissue", n_rd - s_rd, 0);
    chk("rstw_rdata_kept0", p0_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
